// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with double-buffered period/high-time
// configuration that is applied only at period boundaries, plus a global phase-align sync.
module clk_div_multi #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 32,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             cfg_wr,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic [N_CH-1:0]  clk_o,
   output logic [N_CH-1:0]  tick_o,
   output logic [N_CH-1:0]  pending_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] count_q, count_d;
         logic [CNT_W-1:0] act_p_q, act_p_d;
         logic [CNT_W-1:0] act_h_q, act_h_d;
         logic [CNT_W-1:0] sh_p_q, sh_p_d;
         logic [CNT_W-1:0] sh_h_q, sh_h_d;
         logic             pend_q, pend_d;
         logic             run_q, run_d;
         logic             clk_q, clk_d;
         logic             tick_q, tick_d;
         logic             wr_hit;
         logic             wrap;
         logic             stopped;

         always_comb begin
            // Out-of-range channel numbers never match any gi, so those writes are dropped.
            wr_hit  = cfg_wr && (cfg_ch == CH_W'(gi));
            stopped = !en[gi] || (act_p_q == '0);
            wrap    = run_q && (count_q == act_p_q - CNT_W'(1));

            sh_p_d  = sh_p_q;
            sh_h_d  = sh_h_q;
            act_p_d = act_p_q;
            act_h_d = act_h_q;
            pend_d  = pend_q;
            count_d = '0;

            if (wr_hit) begin
               sh_p_d = cfg_period;
               sh_h_d = cfg_high;
               pend_d = 1'b1;
            end

            if (sync && en[gi]) begin
               // A write in the sync cycle is the newest config and is taken directly.
               if (wr_hit) begin
                  act_p_d = cfg_period;
                  act_h_d = cfg_high;
                  pend_d  = 1'b0;
               end else if (pend_q) begin
                  act_p_d = sh_p_q;
                  act_h_d = sh_h_q;
                  pend_d  = 1'b0;
               end
            end else if (pend_q && (wrap || stopped)) begin
               // The old shadow goes live; a write landing on this same edge stays pending.
               act_p_d = sh_p_q;
               act_h_d = sh_h_q;
               pend_d  = wr_hit;
            end else if (run_q && en[gi] && !wrap) begin
               count_d = count_q + CNT_W'(1);
            end

            run_d  = en[gi] && (act_p_d != '0);
            clk_d  = run_d && (count_d < act_h_d);
            tick_d = run_d && (count_d == '0);
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               count_q <= '0;
               act_p_q <= '0;
               act_h_q <= '0;
               sh_p_q  <= '0;
               sh_h_q  <= '0;
               pend_q  <= 1'b0;
               run_q   <= 1'b0;
               clk_q   <= 1'b0;
               tick_q  <= 1'b0;
            end else begin
               count_q <= count_d;
               act_p_q <= act_p_d;
               act_h_q <= act_h_d;
               sh_p_q  <= sh_p_d;
               sh_h_q  <= sh_h_d;
               pend_q  <= pend_d;
               run_q   <= run_d;
               clk_q   <= clk_d;
               tick_q  <= tick_d;
            end
         end

         assign clk_o[gi]     = clk_q;
         assign tick_o[gi]    = tick_q;
         assign pending_o[gi] = pend_q;
      end
   endgenerate

endmodule
